spell_wb_host: RTL and testbench
================================

// Module: spell_wb_host
// PURPOSE
//  Wishbone initiator driving the spell core's register slave (PC/SP/EXEC/RUN/...).
//  Accepts write/read/poll commands on a valid/ready port, issues single Wishbone
//  cycles with a one-cycle strobe, and returns read data on a response port.
//  Used by the test harness and debug loader to step, run and inspect spell.
// PARAMETERS
//  ADDR_W      24  Wishbone address bits driven (upper o_wb_addr bits tied 0)
//  POLL_GAP    4   idle cycles between successive poll reads (0 = back-to-back)
//  TIMEOUT     64  cycles waiting for ack before abort (SPELL_WB_TIMEOUT_EN only)
// PORTS
//  clock       in   1   system clock
//  reset       in   1   synchronous, active-high reset
//  cmd_valid   in   1   command present
//  cmd_ready   out  1   command accepted when cmd_valid & cmd_ready
//  cmd_op      in   2   00 write, 01 read, 10 poll, 11 reserved (treated as read)
//  cmd_addr    in   ADDR_W  register address
//  cmd_data    in   32  write data (write) / poll mask (poll)
//  rsp_valid   out  1   response present; held until rsp_ready
//  rsp_ready   in   1   response consumed when rsp_valid & rsp_ready
//  rsp_data    out  32  read data (read/poll, last value read); 0 for write
//  rsp_err     out  1   transaction aborted by timeout
//  o_wb_cyc    out  1   bus cycle
//  o_wb_stb    out  1   strobe
//  o_wb_we     out  1   write enable
//  o_wb_addr   out  32  address
//  o_wb_data   out  32  write data
//  i_wb_ack    in   1   slave ack
//  i_wb_data   in   32  slave read data
// BEHAVIOUR
//  - Reset: state IDLE; cmd_ready=1; rsp_valid=0, rsp_data=0, rsp_err=0;
//    o_wb_cyc/stb/we=0, o_wb_addr=0, o_wb_data=0; timers cleared. All outputs registered.
//  - States: IDLE -> STROBE -> WAIT_ACK -> (GAP -> STROBE)* -> RESP -> IDLE.
//  - IDLE: cmd_ready=1. On handshake latch op/addr/data, cmd_ready<=0, go STROBE.
//  - STROBE (1 cycle): cyc=1, stb=1, we=(op==00), addr/data driven. Next: WAIT_ACK.
//  - WAIT_ACK: cyc=1, stb=0, we/addr/data held. stb is never high >1 cycle, so the
//    slave performs exactly one access (no double STACK_PUSH). i_wb_ack sampled 1:
//    cyc<=0; capture i_wb_data for read/poll.
//    - write/read: go RESP.
//    - poll: if (i_wb_data & mask)==0 go RESP; else go GAP (POLL_GAP=0: straight
//      to STROBE). Mask 0 completes after first read.
//  - GAP: cyc=0, counts POLL_GAP cycles, then STROBE with same addr.
//  - RESP: rsp_valid=1 with rsp_data/rsp_err stable; on rsp_ready: rsp_valid<=0,
//    cmd_ready<=1, IDLE. Earliest new command accepted the cycle after RESP exits.
//  - Latency (zero-wait slave, ack one cycle after stb): cmd handshake at edge N,
//    stb high cycle N+1, ack cycle N+2, rsp_valid cycle N+3.
//  - i_wb_ack outside WAIT_ACK (including the cycle STROBE is active) is ignored.
//  - rsp_data for write = 0. Reserved op 11 behaves exactly as read.
//  - Reset mid-transaction: cyc/stb drop on the reset edge; pending response lost.
// CONFIGURATION
//  SPELL_WB_TIMEOUT_EN defined: counter runs in WAIT_ACK only, cleared at STROBE;
//    reaching TIMEOUT cycles without ack -> cyc<=0, rsp_data<=0, rsp_err<=1, RESP.
//    Poll aborts on any single read timing out. Late ack after abort is ignored.
//  Not defined: WAIT_ACK waits indefinitely; rsp_err constant 0; no counter logic.
// TESTING
//  1 write 0x00c<-0x1 to spell model -> one stb-high cycle, we=1, single ack,
//    rsp_valid 3 cycles after handshake, rsp_data=0, rsp_err=0.
//  2 read 0x000 with slave PC=0x2a -> rsp_data=0x0000002a; rsp_ready held low 5
//    cycles -> rsp_valid and data stable, cmd_ready=0 throughout.
//  3 poll 0x00c mask 0x1, slave returns 1,1,0 -> exactly 3 stb pulses spaced
//    POLL_GAP+2 cycles apart, rsp_data=0.
//  4 two STACK_PUSH writes back-to-back -> slave SP increments by exactly 2.
//  5 SPELL_WB_TIMEOUT_EN, slave never acks -> cyc drops after 64 cycles,
//    rsp_err=1, rsp_data=0; next read to live slave succeeds with rsp_err=0.
//  6 reset asserted in WAIT_ACK -> next cycle cyc=stb=0, rsp_valid=0, cmd_ready=1.

Source files
------------

// File: rtl/spell_wb_host_if.sv
// Command, response and Wishbone signal bundle for spell_wb_host.
// master = the host itself, slave = the harness side driving commands and acks.
interface spell_wb_host_if #(
  parameter int ADDR_W = 24
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_err;
  logic              o_wb_cyc;
  logic              o_wb_stb;
  logic              o_wb_we;
  logic [31:0]       o_wb_addr;
  logic [31:0]       o_wb_data;
  logic              i_wb_ack;
  logic [31:0]       i_wb_data;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, i_wb_ack, i_wb_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, i_wb_ack, i_wb_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data
  );
endinterface

// File: rtl/spell_wb_host.sv
// Wishbone initiator for the spell register slave: write/read/poll commands, one-cycle strobes.
// Define SPELL_WB_TIMEOUT_EN to abort transactions whose ack does not arrive within TIMEOUT cycles.
module spell_wb_host #(
  parameter int ADDR_W   = 24,
  parameter int POLL_GAP = 4,
  parameter int TIMEOUT  = 64
) (
  input logic             clock,
  input logic             reset,
  spell_wb_host_if.master bus
);
  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_POLL  = 2'b10;
  localparam int         GAP_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT_ACK,
    S_GAP,
    S_RESP
  } state_t;

  state_t           r_state, w_state;
  logic [1:0]       r_op, w_op;
  logic             r_cmdReady, w_cmdReady;
  logic             r_rspValid, w_rspValid;
  logic [31:0]      r_rspData, w_rspData;
  logic             r_cyc, w_cyc;
  logic             r_stb, w_stb;
  logic             r_we, w_we;
  logic [31:0]      r_wbAddr, w_wbAddr;
  logic [31:0]      r_wbData, w_wbData;
  logic [GAP_W-1:0] r_gapCnt, w_gapCnt;
  logic [31:0]      w_addrExt;
  logic             w_pollHit;

  assign w_addrExt = 32'(bus.cmd_addr[ADDR_W-1:0]);
  // During a poll the latched write data doubles as the completion mask.
  assign w_pollHit = (r_op == OP_POLL) && ((bus.i_wb_data & r_wbData) != 32'd0);

`ifdef SPELL_WB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TO_W-1:0] r_toCnt, w_toCnt;
  logic            r_rspErr, w_rspErr;
  assign bus.rsp_err = r_rspErr;
`else
  assign bus.rsp_err = 1'b0;
  if (TIMEOUT < 1) begin : gTimeoutUnused
  end
`endif

  always_comb begin
    w_state    = r_state;
    w_op       = r_op;
    w_cmdReady = r_cmdReady;
    w_rspValid = r_rspValid;
    w_rspData  = r_rspData;
    w_cyc      = r_cyc;
    w_stb      = r_stb;
    w_we       = r_we;
    w_wbAddr   = r_wbAddr;
    w_wbData   = r_wbData;
    w_gapCnt   = r_gapCnt;
`ifdef SPELL_WB_TIMEOUT_EN
    w_toCnt    = r_toCnt;
    w_rspErr   = r_rspErr;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid && r_cmdReady) begin
          w_op       = bus.cmd_op;
          w_wbAddr   = w_addrExt;
          w_wbData   = bus.cmd_data;
          w_we       = (bus.cmd_op == OP_WRITE);
          w_cyc      = 1'b1;
          w_stb      = 1'b1;
          w_cmdReady = 1'b0;
          w_state    = S_STROBE;
        end
      end
      S_STROBE: begin
        w_stb   = 1'b0;
        w_state = S_WAIT_ACK;
`ifdef SPELL_WB_TIMEOUT_EN
        w_toCnt = '0;
`endif
      end
      S_WAIT_ACK: begin
        if (bus.i_wb_ack) begin
          w_cyc     = 1'b0;
          w_rspData = (r_op == OP_WRITE) ? 32'd0 : bus.i_wb_data;
`ifdef SPELL_WB_TIMEOUT_EN
          w_rspErr  = 1'b0;
`endif
          if (w_pollHit) begin
            if (POLL_GAP == 0) begin
              w_cyc   = 1'b1;
              w_stb   = 1'b1;
              w_state = S_STROBE;
            end else begin
              w_gapCnt = '0;
              w_state  = S_GAP;
            end
          end else begin
            w_rspValid = 1'b1;
            w_state    = S_RESP;
          end
        end
`ifdef SPELL_WB_TIMEOUT_EN
        else if (r_toCnt == TO_W'(TIMEOUT - 1)) begin
          w_cyc      = 1'b0;
          w_rspData  = 32'd0;
          w_rspErr   = 1'b1;
          w_rspValid = 1'b1;
          w_state    = S_RESP;
        end else begin
          w_toCnt = r_toCnt + 1'b1;
        end
`endif
      end
      S_GAP: begin
        if (r_gapCnt == GAP_W'(POLL_GAP - 1)) begin
          w_cyc   = 1'b1;
          w_stb   = 1'b1;
          w_state = S_STROBE;
        end else begin
          w_gapCnt = r_gapCnt + 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_rspValid = 1'b0;
          w_cmdReady = 1'b1;
          w_state    = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op       <= OP_WRITE;
      r_cmdReady <= 1'b1;
      r_rspValid <= 1'b0;
      r_rspData  <= 32'd0;
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
      r_we       <= 1'b0;
      r_wbAddr   <= 32'd0;
      r_wbData   <= 32'd0;
      r_gapCnt   <= '0;
`ifdef SPELL_WB_TIMEOUT_EN
      r_toCnt    <= '0;
      r_rspErr   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state;
      r_op       <= w_op;
      r_cmdReady <= w_cmdReady;
      r_rspValid <= w_rspValid;
      r_rspData  <= w_rspData;
      r_cyc      <= w_cyc;
      r_stb      <= w_stb;
      r_we       <= w_we;
      r_wbAddr   <= w_wbAddr;
      r_wbData   <= w_wbData;
      r_gapCnt   <= w_gapCnt;
`ifdef SPELL_WB_TIMEOUT_EN
      r_toCnt    <= w_toCnt;
      r_rspErr   <= w_rspErr;
`endif
    end
  end

  assign bus.cmd_ready = r_cmdReady;
  assign bus.rsp_valid = r_rspValid;
  assign bus.rsp_data  = r_rspData;
  assign bus.o_wb_cyc  = r_cyc;
  assign bus.o_wb_stb  = r_stb;
  assign bus.o_wb_we   = r_we;
  assign bus.o_wb_addr = r_wbAddr;
  assign bus.o_wb_data = r_wbData;
endmodule

// File: tb/tb_spell_wb_host.sv
// Directed bench for spell_wb_host: vector table plus hand sequences for hold, poll, push and reset.
// A zero-wait spell register model acks one cycle after each strobe.
module tb_spell_wb_host;
  localparam int POLL_GAP = 4;
  localparam logic [1:0] OP_WR = 2'b00, OP_RD = 2'b01, OP_POLL = 2'b10, OP_RSV = 2'b11;

  logic clock;
  logic reset;
  spell_wb_host_if #(.ADDR_W(24)) busIf();

  spell_wb_host #(.ADDR_W(24), .POLL_GAP(POLL_GAP), .TIMEOUT(64)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (busIf.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int totalChecks = 0;
  int badChecks   = 0;

  // Register model: PC at 0x000, SP at 0x004, EXEC poll source at 0x00c, push at 0x010, scratch at 0x020.
  bit          ackEnable = 1'b1;
  logic [31:0] spReg = 32'h100;
  logic [31:0] scratchReg = 32'h0;
  logic [31:0] pollSeq [3] = '{32'h1, 32'h1, 32'h0};
  int          pollIdx = 0;

  function automatic logic [31:0] readReg(input logic [31:0] a);
    case (a)
      32'h000: return 32'h2a;
      32'h004: return spReg;
      32'h00c: return pollSeq[pollIdx];
      32'h020: return scratchReg;
      default: return 32'hbad00000;
    endcase
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      busIf.i_wb_ack <= 1'b0;
      pollIdx        <= 0;
    end else if (busIf.o_wb_cyc && busIf.o_wb_stb && ackEnable) begin
      busIf.i_wb_ack <= 1'b1;
      if (busIf.o_wb_we) begin
        if (busIf.o_wb_addr == 32'h010) spReg <= spReg + 1;
        if (busIf.o_wb_addr == 32'h020) scratchReg <= busIf.o_wb_data;
      end else begin
        busIf.i_wb_data <= readReg(busIf.o_wb_addr);
        if (busIf.o_wb_addr == 32'h00c && pollIdx < 2) pollIdx <= pollIdx + 1;
      end
    end else begin
      busIf.i_wb_ack <= 1'b0;
    end
  end

  // Strobe monitor: counts pulses, their cycle numbers, back-to-back strobes and the last access.
  int          cycleNum = 0;
  int          stbCount = 0;
  int          stbDouble = 0;
  int          stbCycle [64];
  logic        prevStb = 1'b0;
  logic        lastWe = 1'b0;
  logic [31:0] lastAddr = 32'h0;

  always @(posedge clock) begin
    cycleNum <= cycleNum + 1;
    prevStb  <= busIf.o_wb_stb;
    if (busIf.o_wb_stb) begin
      stbCount <= stbCount + 1;
      if (stbCount < 64) stbCycle[stbCount] <= cycleNum;
      lastWe   <= busIf.o_wb_we;
      lastAddr <= busIf.o_wb_addr;
      if (prevStb) stbDouble <= stbDouble + 1;
    end
  end

  int          gotLat;
  logic [31:0] gotData;
  logic        gotErr;
  int          stbAtStart;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Issues one command and waits (bounded) for the response; gotLat counts cycles after the handshake.
  task automatic applyStimulus(input logic [1:0] op, input logic [23:0] addr, input logic [31:0] data);
    int waitCnt;
    @(negedge clock);
    waitCnt = 0;
    while (!busIf.cmd_ready && waitCnt < 20) begin
      @(negedge clock);
      waitCnt++;
    end
    busIf.cmd_valid = 1'b1;
    busIf.cmd_op    = op;
    busIf.cmd_addr  = addr;
    busIf.cmd_data  = data;
    stbAtStart      = stbCount;
    @(posedge clock);
    #1 busIf.cmd_valid = 1'b0;
    gotLat = 0;
    do begin
      @(negedge clock);
      gotLat++;
    end while (!busIf.rsp_valid && gotLat < 200);
    gotData = busIf.rsp_data;
    gotErr  = busIf.rsp_err;
  endtask

  task automatic releaseRsp();
    busIf.rsp_ready = 1'b1;
    @(posedge clock);
    #1 busIf.rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [23:0] addr;
    logic [31:0] data;
    logic [31:0] expData;
    int          expStb;
    logic        expWe;
  } vec_t;

  vec_t vecs [9];
  logic [31:0] spBefore;

  initial begin
    vecs[0] = '{OP_WR,   24'h00c, 32'h00000001, 32'h00000000, 1, 1'b1};
    vecs[1] = '{OP_WR,   24'h020, 32'hdeadbeef, 32'h00000000, 1, 1'b1};
    vecs[2] = '{OP_RD,   24'h020, 32'h00000000, 32'hdeadbeef, 1, 1'b0};
    vecs[3] = '{OP_RD,   24'h000, 32'h00000000, 32'h0000002a, 1, 1'b0};
    vecs[4] = '{OP_RSV,  24'h020, 32'h00000000, 32'hdeadbeef, 1, 1'b0};
    vecs[5] = '{OP_POLL, 24'h020, 32'h00000000, 32'hdeadbeef, 1, 1'b0};
    vecs[6] = '{OP_POLL, 24'h020, 32'h00000010, 32'hdeadbeef, 1, 1'b0};
    vecs[7] = '{OP_WR,   24'h020, 32'h00000000, 32'h00000000, 1, 1'b1};
    vecs[8] = '{OP_RD,   24'h020, 32'h00000000, 32'h00000000, 1, 1'b0};

    reset           = 1'b1;
    busIf.cmd_valid = 1'b0;
    busIf.cmd_op    = 2'b00;
    busIf.cmd_addr  = '0;
    busIf.cmd_data  = '0;
    busIf.rsp_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("rst cmd_ready", 32'(busIf.cmd_ready), 32'd1);
    checkOutput("rst rsp_valid", 32'(busIf.rsp_valid), 32'd0);
    checkOutput("rst rsp_data", busIf.rsp_data, 32'd0);
    checkOutput("rst rsp_err", 32'(busIf.rsp_err), 32'd0);
    checkOutput("rst cyc", 32'(busIf.o_wb_cyc), 32'd0);
    checkOutput("rst stb", 32'(busIf.o_wb_stb), 32'd0);
    checkOutput("rst we", 32'(busIf.o_wb_we), 32'd0);
    checkOutput("rst addr", busIf.o_wb_addr, 32'd0);
    checkOutput("rst wdata", busIf.o_wb_data, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].data);
      checkOutput($sformatf("vec%0d data", i), gotData, vecs[i].expData);
      checkOutput($sformatf("vec%0d err", i), 32'(gotErr), 32'd0);
      checkOutput($sformatf("vec%0d latency", i), 32'(gotLat), 32'd3);
      checkOutput($sformatf("vec%0d stb pulses", i), 32'(stbCount - stbAtStart), 32'(vecs[i].expStb));
      checkOutput($sformatf("vec%0d we", i), 32'(lastWe), 32'(vecs[i].expWe));
      checkOutput($sformatf("vec%0d addr", i), lastAddr, 32'(vecs[i].addr));
      releaseRsp();
    end

    applyStimulus(OP_RD, 24'h000, 32'h0);
    checkOutput("hold data", gotData, 32'h2a);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      checkOutput($sformatf("hold%0d rsp_valid", k), 32'(busIf.rsp_valid), 32'd1);
      checkOutput($sformatf("hold%0d rsp_data", k), busIf.rsp_data, 32'h2a);
      checkOutput($sformatf("hold%0d cmd_ready", k), 32'(busIf.cmd_ready), 32'd0);
    end
    releaseRsp();

    applyStimulus(OP_POLL, 24'h00c, 32'h1);
    checkOutput("poll data", gotData, 32'h0);
    checkOutput("poll stb pulses", 32'(stbCount - stbAtStart), 32'd3);
    checkOutput("poll latency", 32'(gotLat), 32'(3 + 2 * (POLL_GAP + 2)));
    if (stbAtStart + 2 < 64) begin
      checkOutput("poll gap1", 32'(stbCycle[stbAtStart + 1] - stbCycle[stbAtStart]), 32'(POLL_GAP + 2));
      checkOutput("poll gap2", 32'(stbCycle[stbAtStart + 2] - stbCycle[stbAtStart + 1]), 32'(POLL_GAP + 2));
    end
    releaseRsp();

    applyStimulus(OP_RD, 24'h004, 32'h0);
    spBefore = gotData;
    releaseRsp();
    applyStimulus(OP_WR, 24'h010, 32'h0);
    releaseRsp();
    applyStimulus(OP_WR, 24'h010, 32'h0);
    releaseRsp();
    applyStimulus(OP_RD, 24'h004, 32'h0);
    checkOutput("push sp", gotData, spBefore + 32'd2);
    releaseRsp();
    checkOutput("stb double", 32'(stbDouble), 32'd0);

`ifdef SPELL_WB_TIMEOUT_EN
    ackEnable = 1'b0;
    applyStimulus(OP_RD, 24'h000, 32'h0);
    checkOutput("timeout latency", 32'(gotLat), 32'd66);
    checkOutput("timeout err", 32'(gotErr), 32'd1);
    checkOutput("timeout data", gotData, 32'd0);
    checkOutput("timeout cyc", 32'(busIf.o_wb_cyc), 32'd0);
    releaseRsp();
    ackEnable = 1'b1;
    applyStimulus(OP_RD, 24'h000, 32'h0);
    checkOutput("after timeout data", gotData, 32'h2a);
    checkOutput("after timeout err", 32'(gotErr), 32'd0);
    releaseRsp();
`endif

    ackEnable = 1'b0;
    @(negedge clock);
    busIf.cmd_valid = 1'b1;
    busIf.cmd_op    = OP_RD;
    busIf.cmd_addr  = 24'h000;
    @(posedge clock);
    #1 busIf.cmd_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checkOutput("wait_ack cyc", 32'(busIf.o_wb_cyc), 32'd1);
    checkOutput("wait_ack stb", 32'(busIf.o_wb_stb), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midrst cyc", 32'(busIf.o_wb_cyc), 32'd0);
    checkOutput("midrst stb", 32'(busIf.o_wb_stb), 32'd0);
    checkOutput("midrst rsp_valid", 32'(busIf.rsp_valid), 32'd0);
    checkOutput("midrst cmd_ready", 32'(busIf.cmd_ready), 32'd1);
    reset     = 1'b0;
    ackEnable = 1'b1;
    applyStimulus(OP_RD, 24'h000, 32'h0);
    checkOutput("post reset data", gotData, 32'h2a);
    checkOutput("post reset latency", 32'(gotLat), 32'd3);
    releaseRsp();

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
